// File: rtl/contador_seq_pkg.sv
// contador_seq_pkg
// Shared definitions for the contador sequencer: sequencer state encoding,
// the counter data width, the width of the step counter and the default
// watchdog limit (one full wrap of the 4-bit counter).
package contador_seq_pkg;

  localparam int CNT_W         = 4;
  localparam int STEPS_W       = 5;
  localparam int MAX_STEPS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/contador_seq_tick_div.sv
// tick_div
// Loadable down-counter that paces the sequencer's enable pulses.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset, clears the count to 0
//   reload     - load reload_val on the next edge (wins over run)
//   reload_val - value to load
//   run        - decrement the count on the next edge (stops at 0)
//   tick       - high while the count is 0
module tick_div
  import contador_seq_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reload,
  input  logic [DIV_W-1:0] reload_val,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Reload has priority; the count saturates at 0 so a stalled
  // sequencer never sees the divider wrap underneath it.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = reload_val;
    end else if (run && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/contador_seq.sv
// contador_seq
// Sequencer for the 4-bit loadable up/down counter. A host issues a
// start/end/direction/pace command; the block loads the counter, paces
// enable pulses every div+1 cycles and watches the fed-back count until it
// reaches the end value, or flags err after a full wrap without arriving.
// Ports:
//   clk, reset           - clock (rising edge) and async active-low reset
//   start                - command strobe, only honoured in IDLE
//   start_val, end_val   - initial and target counter values
//   dir                  - 1 = up, 0 = down
//   div                  - idle cycles between steps
//   abort                - cancel the running command
//   cont_in              - counter output fed back
//   load, a, b, c, d     - counter parallel load (a = bit 0 .. d = bit 3)
//   enable, updown       - counter step control
//   busy, done, err      - handshake and watchdog status
//   steps                - enable pulses issued for the current command
module contador_seq
  import contador_seq_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   start_val,
  input  logic [CNT_W-1:0]   end_val,
  input  logic               dir,
  input  logic [DIV_W-1:0]   div,
  input  logic               abort,
  input  logic [CNT_W-1:0]   cont_in,
  output logic               load,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               enable,
  output logic               updown,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STEPS_W-1:0] steps
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   end_q, end_d;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic               err_q, err_d;

  logic presc_reload;
  logic presc_run;
  logic presc_tick;
  logic at_end;
  logic at_limit;

  tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk       (clk),
    .reset     (reset),
    .reload    (presc_reload),
    .reload_val(div_q),
    .run       (presc_run),
    .tick      (presc_tick)
  );

  assign at_end   = (cont_in == end_q);
  assign at_limit = (steps_q == STEPS_W'(MAX_STEPS));

  // Next-state and output logic. Abort beats every RUN rule, and the
  // end-value compare beats the watchdog, which beats stepping, so enable
  // can never coincide with a matching count.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    dir_d        = dir_q;
    div_d        = div_q;
    steps_d      = steps_q;
    err_d        = err_q;
    load         = 1'b0;
    enable       = 1'b0;
    done         = 1'b0;
    presc_reload = 1'b0;
    presc_run    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_d = start_val;
          end_d   = end_val;
          dir_d   = dir;
          div_d   = div;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          load         = 1'b1;
          presc_reload = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = DONE;
        end else if (at_limit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (presc_tick) begin
          enable       = 1'b1;
          presc_reload = 1'b1;
          steps_d      = steps_q + 1'b1;
        end else begin
          presc_run = 1'b1;
        end
      end
      DONE: begin
        done    = !abort;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  // The latched command drives the counter's data and direction pins
  // continuously, so updown is already stable on every enable pulse.
  assign a      = start_q[0];
  assign b      = start_q[1];
  assign c      = start_q[2];
  assign d      = start_q[3];
  assign updown = dir_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_contador_seq.sv
// tb_contador_seq
// Bench for contador_seq. A behavioural 4-bit counter closes the loop on
// cont_in (optionally stuck at 0). The expected outputs come from a
// timeline model: from the accepted command it derives the number of
// steps by modular arithmetic and the cycle of every load, enable and done
// event from the pacing formula. Directed scenarios add literal checks.
`timescale 1ns/1ps
module tb_contador_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_val = '0;
  logic [3:0] end_val = '0;
  logic       dir = 1'b0;
  logic [7:0] div = '0;
  logic       abort = 1'b0;
  logic [3:0] cont_in;
  logic       load, a, b, c, d, enable, updown, busy, done, err;
  logic [4:0] steps;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  stuck = 1'b0;
  logic [3:0] cnt;

  // Timeline model of the current command.
  bit  cmd_valid = 1'b0;
  int  t0 = 0;
  int  m_sv = 0, m_ev = 0, m_dir = 0, m_div = 0, m_n = 0, m_abort = -1;
  bit  m_stuck = 1'b0;
  int  p_steps = 0, p_err = 0, p_sv = 0, p_dir = 0;

  // Event monitors.
  int  en_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int  last_en_cyc = 0, last_done_cyc = 0, last_load_cyc = 0;

  contador_seq #(
    .DIV_W(8),
    .MAX_STEPS(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_val(start_val),
    .end_val  (end_val),
    .dir      (dir),
    .div      (div),
    .abort    (abort),
    .cont_in  (cont_in),
    .load     (load),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .enable   (enable),
    .updown   (updown),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .steps    (steps)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counter being sequenced.
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 4'd0;
    else if (load) cnt <= {d, c, b, a};
    else if (enable) cnt <= updown ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign cont_in = stuck ? 4'd0 : cnt;

  function automatic int done_rel();
    return m_n * (m_div + 1) + 3;
  endfunction

  function automatic int last_rel();
    return (m_abort >= 0) ? m_abort : done_rel();
  endfunction

  function automatic int en_at(int r);
    int p;
    p = m_div + 1;
    if (r < 2 || r > last_rel() || r == m_abort) return 0;
    return (((r - 2) % p) == m_div && ((r - 2) / p) < m_n) ? 1 : 0;
  endfunction

  function automatic int steps_at(int r);
    int n, ec;
    n = 0;
    for (int k = 0; k < m_n; k++) begin
      ec = 2 + k * (m_div + 1) + m_div;
      if (ec < r && (m_abort < 0 || ec < m_abort)) n++;
    end
    return n;
  endfunction

  function automatic int err_at(int r);
    return (m_stuck && r >= done_rel() && (m_abort < 0 || m_abort >= done_rel())) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs and let the model react to them.
  task automatic applyStimulus(input bit st, input logic [3:0] sv, input logic [3:0] ev,
                               input bit dr, input logic [7:0] dv, input bit ab);
    int  r;
    bit  idle_m;
    @(posedge clk);
    #1;
    start = st; start_val = sv; end_val = ev; dir = dr; div = dv; abort = ab;
    r = cyc - t0;
    idle_m = !cmd_valid || (r > last_rel());
    if (ab && !idle_m && r >= 1 && m_abort < 0) m_abort = r;
    if (st && idle_m) begin
      if (cmd_valid) begin
        p_steps = steps_at(1000000);
        p_err   = err_at(1000000);
        p_sv    = m_sv;
        p_dir   = m_dir;
      end
      cmd_valid = 1'b1;
      t0 = cyc;
      m_sv = int'(sv); m_ev = int'(ev); m_dir = int'(dr); m_div = int'(dv);
      m_abort = -1;
      m_stuck = stuck;
      if (stuck) m_n = 16;
      else if (dr) m_n = ((m_ev - m_sv) % 16 + 16) % 16;
      else m_n = ((m_sv - m_ev) % 16 + 16) % 16;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic model_reset();
    cmd_valid = 1'b0;
    m_abort = -1;
    p_steps = 0; p_err = 0; p_sv = 0; p_dir = 0;
  endtask

  // Every-cycle comparison against the timeline model.
  always @(negedge clk) begin
    int r;
    int e_busy, e_load, e_en, e_done, e_steps, e_err, e_sv, e_dir;
    r = cyc - t0;
    if (!cmd_valid || r == 0) begin
      e_busy = 0; e_load = 0; e_en = 0; e_done = 0;
      e_steps = p_steps; e_err = p_err; e_sv = p_sv; e_dir = p_dir;
    end else begin
      e_busy  = (r <= last_rel()) ? 1 : 0;
      e_load  = (r == 1 && m_abort != 1) ? 1 : 0;
      e_en    = en_at(r);
      e_done  = (r == done_rel() && m_abort < 0) ? 1 : 0;
      e_steps = steps_at(r);
      e_err   = err_at(r);
      e_sv    = m_sv;
      e_dir   = m_dir;
    end
    checkOutput("busy", int'(busy), e_busy);
    checkOutput("load", int'(load), e_load);
    checkOutput("enable", int'(enable), e_en);
    checkOutput("done", int'(done), e_done);
    checkOutput("steps", int'(steps), e_steps);
    checkOutput("err", int'(err), e_err);
    checkOutput("abcd", int'({d, c, b, a}), e_sv);
    checkOutput("updown", int'(updown), e_dir);
  end

  always @(negedge clk) begin
    if (enable) begin en_cnt++; last_en_cyc = cyc; end
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (load) last_load_cyc = cyc;
    if (busy) busy_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int ts, e0, dn0, b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Basic up count 3 -> 7, one step per cycle.
    $display("[TB] basic up");
    applyStimulus(1'b1, 4'd3, 4'd7, 1'b1, 8'd0, 1'b0);
    ts = cyc; e0 = en_cnt; dn0 = done_cnt;
    idle_cycles(10);
    checkOutput("t1_load_cycle", last_load_cyc - ts, 1);
    checkOutput("t1_last_enable_cycle", last_en_cyc - ts, 5);
    checkOutput("t1_enable_count", en_cnt - e0, 4);
    checkOutput("t1_done_cycle", last_done_cyc - ts, 7);
    checkOutput("t1_done_count", done_cnt - dn0, 1);
    checkOutput("t1_steps", int'(steps), 4);
    checkOutput("t1_err", int'(err), 0);
    checkOutput("t1_cont", int'(cont_in), 7);

    // Down count with wrap 1 -> 14, paced every 3 cycles.
    $display("[TB] down with wrap");
    applyStimulus(1'b1, 4'd1, 4'd14, 1'b0, 8'd2, 1'b0);
    ts = cyc; e0 = en_cnt;
    idle_cycles(14);
    checkOutput("t2_enable_count", en_cnt - e0, 3);
    checkOutput("t2_last_enable_cycle", last_en_cyc - ts, 10);
    checkOutput("t2_done_cycle", last_done_cyc - ts, 12);
    checkOutput("t2_steps", int'(steps), 3);
    checkOutput("t2_cont", int'(cont_in), 14);

    // Zero-length command.
    $display("[TB] zero length");
    b0 = busy_cnt;
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b1, 8'd5, 1'b0);
    ts = cyc; e0 = en_cnt;
    idle_cycles(6);
    checkOutput("t3_enable_count", en_cnt - e0, 0);
    checkOutput("t3_done_cycle", last_done_cyc - ts, 3);
    checkOutput("t3_busy_cycles", busy_cnt - b0, 3);
    checkOutput("t3_steps", int'(steps), 0);

    // Abort in cycle 10 of an up 0 -> 15 command, restart in cycle 12.
    $display("[TB] abort");
    applyStimulus(1'b1, 4'd0, 4'd15, 1'b1, 8'd3, 1'b0);
    ts = cyc; e0 = en_cnt; dn0 = done_cnt;
    idle_cycles(9);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'd0, 1'b1);
    idle_cycles(1);
    checkOutput("t4_busy_after_abort", int'(busy), 0);
    checkOutput("t4_steps_after_abort", int'(steps), 2);
    checkOutput("t4_cont_after_abort", int'(cont_in), 2);
    applyStimulus(1'b1, 4'd2, 4'd4, 1'b1, 8'd0, 1'b0);
    checkOutput("t4_enable_count", en_cnt - e0, 2);
    checkOutput("t4_no_done", done_cnt - dn0, 0);
    idle_cycles(1);
    checkOutput("t4_restart_load", int'(load), 1);
    idle_cycles(7);
    checkOutput("t4_restart_steps", int'(steps), 2);

    // Watchdog with a counter stuck at 0.
    $display("[TB] watchdog");
    stuck = 1'b1;
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 8'd0, 1'b0);
    ts = cyc; e0 = en_cnt;
    idle_cycles(22);
    checkOutput("t5_enable_count", en_cnt - e0, 16);
    checkOutput("t5_done_cycle", last_done_cyc - ts, 19);
    checkOutput("t5_steps", int'(steps), 16);
    checkOutput("t5_err", int'(err), 1);
    stuck = 1'b0;

    // Ignored start during RUN, then async reset while enable is high.
    $display("[TB] ignored start and reset");
    applyStimulus(1'b1, 4'd4, 4'd12, 1'b1, 8'd1, 1'b0);
    idle_cycles(5);
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0);
    idle_cycles(3);
    checkOutput("t6_steps_before_reset", int'(steps), 3);
    checkOutput("t6_enable_before_reset", int'(enable), 1);
    #1 reset = 1'b0;
    model_reset();
    #1;
    checkOutput("t6_busy_in_reset", int'(busy), 0);
    checkOutput("t6_enable_in_reset", int'(enable), 0);
    checkOutput("t6_load_in_reset", int'(load), 0);
    checkOutput("t6_steps_in_reset", int'(steps), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Randomized traffic against the timeline model.
    $display("[TB] random");
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 3)), $urandom_range(0, 40) == 0);
    end
    idle_cycles(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_seq.md
Name: contador_seq

Overview:
- Sequencer for the 4-bit loadable up/down counter (`contador`).
- Accepts a start/end/direction/pace command from a host through a start/busy/done handshake.
- Drives the counter's load, a..d, enable and updown inputs.
- Watches the counter's `cont` output to detect arrival at the end value, and flags an error if the counter fails to arrive within one full wrap.

Parameters:
- DIV_W, 8: width of the pace divider field `div`.
- MAX_STEPS, 16: watchdog limit on enable pulses per command (one full 4-bit wrap).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- start_val  in  4  value loaded into the counter.
- end_val  in  4  target value.
- dir  in  1  1 = count up, 0 = count down.
- div  in  DIV_W  idle cycles between steps; a step occurs every div+1 cycles.
- abort  in  1  cancel the current command.
- cont_in  in  4  counter output `cont`, fed back.
- load  out  1  to counter load.
- a, b, c, d  out  1 each  to counter a..d; carry start_val[0..3].
- enable  out  1  to counter enable.
- updown  out  1  to counter updown.
- busy  out  1  high whenever the block is not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  watchdog status; valid with done, held until the next accepted start.
- steps  out  5  count of enable pulses issued for the current command.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - load, enable, done, err, busy = 0; steps=0; prescaler=0.
  - a..d=0; updown=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On start=1, latch start_val, end_val, dir and div; clear steps and err; go to LOAD.
  - start is ignored in every state other than IDLE.
- LOAD (exactly 1 cycle):
  - load=1 and a..d = latched start_val bits.
  - Prescaler <= latched div.
  - Go to RUN.
  - The counter captures the value at the end of this cycle, so cont_in equals start_val on the first RUN cycle.
- RUN, evaluated each cycle in this priority order:
  1. cont_in == end_val: go to DONE; enable=0.
  2. steps == MAX_STEPS: set err=1; go to DONE; enable=0.
  3. prescaler == 0: enable=1; prescaler <= div; steps <= steps+1.
  4. Otherwise: prescaler <= prescaler-1.
- enable is combinational from the registered state, prescaler and the cont_in compare. It is never high in the same cycle that the compare matches.
- updown = latched dir for the whole command. It is held in every state so it is stable whenever enable is high.
- DONE (exactly 1 cycle): done=1; go to IDLE. err stays valid until the next accepted start.
- Latency, measured from the edge that samples start (cycle 0), with N the number of steps required:
  - Step k (1..N) has enable high in RUN cycle (k-1)(div+1)+div, where RUN cycle 0 is absolute cycle 2.
  - done is high in absolute cycle N(div+1)+3.
  - busy rises in cycle 1 and falls in cycle N(div+1)+4.
- Wrap-around is modulo 16 and is governed by the counter.
  - Up: N = (end_val - start_val) mod 16.
  - Down: N = (start_val - end_val) mod 16.
- start_val == end_val gives N=0: no enable pulses, done in cycle 3.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; load and enable are 0 in that cycle.
  - No done pulse; err and steps are unchanged.
  - The counter keeps its current value.
- abort in IDLE has no effect. abort has priority over all RUN rules.
- Asynchronous reset mid-command returns the block to IDLE immediately, with all outputs at their reset values.
- div=0 means one step per cycle: back-to-back enable pulses.

Decomposition:
- Shared header `contador_defs.vh`:
  - state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - CNT_W=4;
  - MAX_STEPS default.
- One natural sub-module, `tick_div`:
  - loadable down-counter of width DIV_W;
  - inputs reload, reload_val, run;
  - output tick when the count is 0.
- The FSM, step counter and compare stay in `contador_seq`.

Test Plan:
- Basic up: start_val=3, end_val=7, dir=1, div=0 → load pulse in cycle 1; enable high in cycles 2..5; cont goes 3→7; done in cycle 7; steps=4; err=0.
- Down with wrap and pacing: start_val=1, end_val=14, dir=0, div=2 → cont goes 1,0,15,14; enable in cycles 4, 7, 10; done in cycle 12; steps=3.
- Zero-length: start_val=9, end_val=9, div=5 → no enable; done in cycle 3; steps=0; busy high in cycles 1..3 only.
- Abort: up 0→15, div=3; assert abort in cycle 10 → enable stays 0 afterwards; no done pulse; busy=0 from cycle 11; a start in cycle 12 is accepted.
- Watchdog: feed cont_in from a stuck model (constant 0), end_val=5, div=0 → 16 enable pulses; done with err=1; steps=16.
- Reset and ignored start: pulse start during RUN → no effect; drive reset low mid-RUN → busy, enable and load go 0 asynchronously, with no clock edge needed.
